// File: rtl/conv_calc_sequencer.sv
// Compute-phase sequencer for the 2D convolution datapath: scans output windows and kernel taps,
// issuing RAM read addresses and pipeline-aligned accumulator / OFMD write strobes.
module conv_calc_sequencer #(
  parameter int unsigned IFMD_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_5x5,
  input  logic       hold,
  output logic       busy,
  output logic       done,
  output logic       rd_valid,
  output logic [5:0] ifmd_rd_addr,
  output logic [4:0] kw_rd_addr,
  output logic       acc_en,
  output logic       acc_load,
  output logic       ofmd_wr,
  output logic [5:0] ofmd_wr_addr
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              is5_q, is5_d;
  logic [2:0]        oy_q, oy_d, ox_q, ox_d, ky_q, ky_d, kx_q, kx_d;
  logic              rd_valid_q, rd_valid_d;
  logic              tap_first_q, tap_first_d, tap_last_q, tap_last_d;
  logic [5:0]        ifmd_rd_addr_q, ifmd_rd_addr_d;
  logic [4:0]        kw_rd_addr_q, kw_rd_addr_d;
  logic [RD_LAT-1:0] en_sr_q, en_sr_d, ld_sr_q, ld_sr_d;
  logic [RD_LAT:0]   wr_sr_q, wr_sr_d;
  logic [5:0]        ofmd_wr_addr_q, ofmd_wr_addr_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic       k5, issue, final_tap;
  logic [2:0] kmax, omax, cy, cx, cky, ckx;
  logic [5:0] last_wr;

  // Geometry and the tap to issue; on start the first tap is issued straight from zero.
  always_comb begin
    k5        = (state_q == StIdle) ? is_5x5 : is5_q;
    kmax      = k5 ? 3'd4 : 3'd2;
    omax      = 3'(IFMD_W - (k5 ? 32'd5 : 32'd3));
    last_wr   = 6'((32'(omax) + 32'd1) * (32'(omax) + 32'd1) - 32'd1);
    if (state_q == StIdle) begin
      {cy, cx, cky, ckx} = '0;
    end else begin
      {cy, cx, cky, ckx} = {oy_q, ox_q, ky_q, kx_q};
    end
    issue     = ((state_q == StIdle) && start) || ((state_q == StRun) && !hold);
    final_tap = (cy == omax) && (cx == omax) && (cky == kmax) && (ckx == kmax);
  end

  always_comb begin
    state_d        = state_q;
    is5_d          = is5_q;
    {oy_d, ox_d, ky_d, kx_d} = {oy_q, ox_q, ky_q, kx_q};
    rd_valid_d     = 1'b0;
    tap_first_d    = 1'b0;
    tap_last_d     = 1'b0;
    ifmd_rd_addr_d = ifmd_rd_addr_q;
    kw_rd_addr_d   = kw_rd_addr_q;
    ofmd_wr_addr_d = ofmd_wr_addr_q;

    if (issue) begin
      rd_valid_d     = 1'b1;
      ifmd_rd_addr_d = 6'((32'(cy) + 32'(cky)) * IFMD_W + 32'(cx) + 32'(ckx));
      kw_rd_addr_d   = 5'(32'(cky) * (32'(kmax) + 32'd1) + 32'(ckx));
      tap_first_d    = (cky == 3'd0) && (ckx == 3'd0);
      tap_last_d     = (cky == kmax) && (ckx == kmax);
      {oy_d, ox_d, ky_d, kx_d} = {cy, cx, cky, ckx};
      if (ckx != kmax) begin
        kx_d = ckx + 3'd1;
      end else begin
        kx_d = 3'd0;
        if (cky != kmax) begin
          ky_d = cky + 3'd1;
        end else begin
          ky_d = 3'd0;
          if (cx != omax) begin
            ox_d = cx + 3'd1;
          end else begin
            ox_d = 3'd0;
            oy_d = cy + 3'd1;
          end
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d        = StRun;
          is5_d          = is_5x5;
          ofmd_wr_addr_d = 6'd0;
        end
      end
      StRun: begin
        if (!hold && final_tap) state_d = StDrain;
      end
      StDrain: begin
        if (wr_sr_q[RD_LAT] && (ofmd_wr_addr_q == last_wr)) state_d = StDone;
      end
      StDone: state_d = StIdle;
    endcase

    if (wr_sr_q[RD_LAT]) ofmd_wr_addr_d = ofmd_wr_addr_q + 6'd1;
    if (state_q == StDone) ofmd_wr_addr_d = 6'd0;

    // Strobe delay lines: the write strobe carries one extra stage so the last product lands.
    en_sr_d[0] = rd_valid_q;
    ld_sr_d[0] = rd_valid_q && tap_first_q;
    wr_sr_d[0] = rd_valid_q && tap_last_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      en_sr_d[i] = en_sr_q[i-1];
      ld_sr_d[i] = ld_sr_q[i-1];
    end
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      wr_sr_d[i] = wr_sr_q[i-1];
    end

    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      is5_q          <= 1'b0;
      oy_q           <= '0;
      ox_q           <= '0;
      ky_q           <= '0;
      kx_q           <= '0;
      rd_valid_q     <= 1'b0;
      tap_first_q    <= 1'b0;
      tap_last_q     <= 1'b0;
      ifmd_rd_addr_q <= '0;
      kw_rd_addr_q   <= '0;
      en_sr_q        <= '0;
      ld_sr_q        <= '0;
      wr_sr_q        <= '0;
      ofmd_wr_addr_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      is5_q          <= is5_d;
      oy_q           <= oy_d;
      ox_q           <= ox_d;
      ky_q           <= ky_d;
      kx_q           <= kx_d;
      rd_valid_q     <= rd_valid_d;
      tap_first_q    <= tap_first_d;
      tap_last_q     <= tap_last_d;
      ifmd_rd_addr_q <= ifmd_rd_addr_d;
      kw_rd_addr_q   <= kw_rd_addr_d;
      en_sr_q        <= en_sr_d;
      ld_sr_q        <= ld_sr_d;
      wr_sr_q        <= wr_sr_d;
      ofmd_wr_addr_q <= ofmd_wr_addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rd_valid     = rd_valid_q;
  assign ifmd_rd_addr = ifmd_rd_addr_q;
  assign kw_rd_addr   = kw_rd_addr_q;
  assign acc_en       = en_sr_q[RD_LAT-1];
  assign acc_load     = ld_sr_q[RD_LAT-1];
  assign ofmd_wr      = wr_sr_q[RD_LAT];
  assign ofmd_wr_addr = ofmd_wr_addr_q;

endmodule

// File: tb/tb_conv_calc_sequencer.sv
// Randomized bench for conv_calc_sequencer: per-cycle trace comparison against a tap-list model,
// with instances at RD_LAT=1 and RD_LAT=2 driven one at a time.
module tb_conv_calc_sequencer;
  localparam int MAXC = 1024;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst, start_a, start_b, is_5x5, hold, sel;
  always #5 clk = ~clk;

  logic       busy_a, done_a, rd_valid_a, acc_en_a, acc_load_a, ofmd_wr_a;
  logic [5:0] ifmd_rd_addr_a, ofmd_wr_addr_a;
  logic [4:0] kw_rd_addr_a;
  logic       busy_b, done_b, rd_valid_b, acc_en_b, acc_load_b, ofmd_wr_b;
  logic [5:0] ifmd_rd_addr_b, ofmd_wr_addr_b;
  logic [4:0] kw_rd_addr_b;

  conv_calc_sequencer #(.IFMD_W(W), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .is_5x5(is_5x5), .hold(hold),
    .busy(busy_a), .done(done_a), .rd_valid(rd_valid_a), .ifmd_rd_addr(ifmd_rd_addr_a),
    .kw_rd_addr(kw_rd_addr_a), .acc_en(acc_en_a), .acc_load(acc_load_a), .ofmd_wr(ofmd_wr_a),
    .ofmd_wr_addr(ofmd_wr_addr_a)
  );

  conv_calc_sequencer #(.IFMD_W(W), .RD_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .is_5x5(is_5x5), .hold(hold),
    .busy(busy_b), .done(done_b), .rd_valid(rd_valid_b), .ifmd_rd_addr(ifmd_rd_addr_b),
    .kw_rd_addr(kw_rd_addr_b), .acc_en(acc_en_b), .acc_load(acc_load_b), .ofmd_wr(ofmd_wr_b),
    .ofmd_wr_addr(ofmd_wr_addr_b)
  );

  logic [22:0] vec_a, vec_b, o_vec;
  assign vec_a = {busy_a, done_a, rd_valid_a, ifmd_rd_addr_a, kw_rd_addr_a, acc_en_a, acc_load_a,
                  ofmd_wr_a, ofmd_wr_addr_a};
  assign vec_b = {busy_b, done_b, rd_valid_b, ifmd_rd_addr_b, kw_rd_addr_b, acc_en_b, acc_load_b,
                  ofmd_wr_b, ofmd_wr_addr_b};
  assign o_vec = sel ? vec_b : vec_a;

  logic       o_busy, o_done, o_valid, o_en, o_ld, o_wr;
  logic [5:0] o_addr, o_wa;
  logic [4:0] o_kw;
  assign {o_busy, o_done, o_valid, o_addr, o_kw, o_en, o_ld, o_wr, o_wa} = o_vec;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected per-cycle trace; cycle 0 is the cycle in which start is driven.
  bit hold_pat[MAXC];
  bit e_valid[MAXC], e_first[MAXC], e_last[MAXC], e_en[MAXC], e_ld[MAXC], e_wr[MAXC];
  bit e_busy[MAXC], e_done[MAXC], e_zero[MAXC];
  int e_addr[MAXC], e_kw[MAXC], e_wa[MAXC];
  int t_addr[400], t_kw[400];
  bit t_first[400], t_last[400];

  task automatic build_model(input bit k5, input int lat, input int abort_c, output int d);
    int kk, o, n, idx, last_c, wa;
    kk = k5 ? 5 : 3;
    o  = W - kk + 1;
    n  = o * o * kk * kk;
    idx = 0;
    for (int oy = 0; oy < o; oy++)
      for (int ox = 0; ox < o; ox++)
        for (int ky = 0; ky < kk; ky++)
          for (int kx = 0; kx < kk; kx++) begin
            t_addr[idx]  = (oy + ky) * W + (ox + kx);
            t_kw[idx]    = ky * kk + kx;
            t_first[idx] = (ky == 0 && kx == 0);
            t_last[idx]  = (ky == kk - 1 && kx == kk - 1);
            idx++;
          end
    for (int c = 0; c < MAXC; c++) begin
      e_valid[c] = 0; e_first[c] = 0; e_last[c] = 0; e_en[c] = 0; e_ld[c] = 0; e_wr[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_zero[c] = 0; e_addr[c] = 0; e_kw[c] = 0; e_wa[c] = 0;
    end
    idx = 0;
    last_c = 1;
    for (int c = 1; idx < n && c < MAXC - 8; c++) begin
      if (c == 1 || !hold_pat[c-1]) begin
        e_valid[c] = 1;
        e_addr[c]  = t_addr[idx];
        e_kw[c]    = t_kw[idx];
        e_first[c] = t_first[idx];
        e_last[c]  = t_last[idx];
        last_c     = c;
        idx++;
      end
    end
    d  = last_c + lat + 2;
    wa = 0;
    for (int c = 1; c <= d; c++) begin
      if (c - lat >= 1) begin
        e_en[c] = e_valid[c-lat];
        e_ld[c] = e_valid[c-lat] && e_first[c-lat];
      end
      if (c - lat - 1 >= 1) e_wr[c] = e_valid[c-lat-1] && e_last[c-lat-1];
      if (e_wr[c]) begin
        e_wa[c] = wa;
        wa++;
      end
      e_busy[c] = (c <= last_c + lat + 1);
      e_done[c] = (c == d);
    end
    if (abort_c > 0) begin
      for (int c = abort_c + 1; c < MAXC; c++) e_zero[c] = 1;
      d = abort_c + 4;
    end
  endtask

  // hmode: 0 none, 1 five cycles after the fifth tap, 2 random bursts.
  task automatic run_pass(input bit k5, input int hmode, input bit noise, input int abort_c,
                          input int exp_done);
    int    d, lat, done_seen, ld_cnt, wr_cnt;
    bit    s;
    string sfx;
    lat = sel ? 2 : 1;
    for (int c = 0; c < MAXC; c++) hold_pat[c] = (hmode == 2) ? ($urandom_range(7) == 0) : 1'b0;
    if (hmode == 1) for (int c = 5; c <= 9; c++) hold_pat[c] = 1'b1;
    build_model(k5, lat, abort_c, d);

    @(posedge clk); #1;
    check_eq("idle_busy", o_busy, 0);
    check_eq("idle_rd_valid", o_valid, 0);
    check_eq("idle_done", o_done, 0);
    start_a = !sel;
    start_b = sel;
    is_5x5  = k5;
    hold    = hold_pat[0];
    done_seen = 0;
    ld_cnt    = 0;
    wr_cnt    = 0;
    for (int c = 1; c <= d; c++) begin
      @(posedge clk); #1;
      sfx = $sformatf("@%0d", c);
      if (e_zero[c]) begin
        check_eq({"rst_outputs", sfx}, 32'(o_vec), 0);
      end else begin
        check_eq({"rd_valid", sfx}, o_valid, e_valid[c]);
        if (e_valid[c]) begin
          check_eq({"ifmd_rd_addr", sfx}, o_addr, e_addr[c]);
          check_eq({"kw_rd_addr", sfx}, o_kw, e_kw[c]);
        end
        check_eq({"acc_en", sfx}, o_en, e_en[c]);
        check_eq({"acc_load", sfx}, o_ld, e_ld[c]);
        check_eq({"ofmd_wr", sfx}, o_wr, e_wr[c]);
        if (e_wr[c]) check_eq({"ofmd_wr_addr", sfx}, o_wa, e_wa[c]);
        check_eq({"busy", sfx}, o_busy, e_busy[c]);
        check_eq({"done", sfx}, o_done, e_done[c]);
      end
      if (o_done) done_seen = c;
      ld_cnt += int'(o_ld);
      wr_cnt += int'(o_wr);
      s = noise && ((c < d) ? ($urandom_range(3) == 0) : 1'b1);
      start_a = !sel && s;
      start_b = sel && s;
      is_5x5  = 1'($urandom_range(1));
      hold    = hold_pat[c];
      rst     = (c == abort_c);
    end
    if (abort_c == 0) begin
      check_eq("done_cycle", done_seen, d);
      if (exp_done != 0) check_eq("done_cycle_const", done_seen, exp_done);
      check_eq("acc_load_count", ld_cnt, k5 ? 16 : 36);
      check_eq("ofmd_wr_count", wr_cnt, k5 ? 16 : 36);
    end else begin
      check_eq("abort_no_done", done_seen, 0);
    end
  endtask

  task automatic idle(input int n);
    start_a = 1'b0;
    start_b = 1'b0;
    hold    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; is_5x5 = 1'b0; hold = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs_a", 32'(vec_a), 0);
    check_eq("reset_outputs_b", 32'(vec_b), 0);
    rst = 1'b0;
    idle(2);
    check_eq("post_reset_a", 32'(vec_a), 0);

    run_pass(1'b0, 0, 1'b0, 0, 327);
    idle(3);
    run_pass(1'b1, 0, 1'b0, 0, 403);
    idle(2);
    run_pass(1'b0, 1, 1'b0, 0, 332);
    idle(2);
    run_pass(1'b0, 0, 1'b1, 0, 327);
    run_pass(1'b1, 0, 1'b1, 0, 403);
    for (int i = 0; i < 3; i++) run_pass(1'($urandom_range(1)), 2, 1'b1, 0, 0);
    idle(2);
    run_pass(1'b0, 0, 1'b0, 100, 0);
    run_pass(1'b0, 0, 1'b0, 0, 327);
    idle(2);

    sel = 1'b1;
    run_pass(1'b0, 0, 1'b0, 0, 328);
    idle(2);
    run_pass(1'($urandom_range(1)), 2, 1'b1, 0, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
